product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_pkg.sv | 11 +
 rtl/product_accumulator_if.sv | 27 ++
 rtl/sat_add.sv | 24 ++
 rtl/product_accumulator.sv | 107 ++++++++++
 4 files changed

// File: rtl/product_pkg.sv
// Shared widths and FSM encoding for the product accumulator slice.
package product_pkg;
    localparam int ACC_W_DEF = 10;
    localparam int PROD_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;
endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream, block controls and result handshake of the accumulator.
interface product_accumulator_if
    import product_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = 4
);
    logic signed [PROD_W-1:0] product;
    logic                     in_valid;
    logic                     in_ready;
    logic [LEN_W-1:0]         len;
    logic                     clear;
    logic signed [ACC_W-1:0]  acc_out;
    logic                     overflow;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output product, in_valid, len, clear, out_ready,
        input  in_ready, acc_out, overflow, out_valid
    );

    modport slave (
        input  product, in_valid, len, clear, out_ready,
        output in_ready, acc_out, overflow, out_valid
    );
endinterface

// File: rtl/sat_add.sv
// Adds a signed product to the accumulator, clamping to the ACC_W signed range.
module sat_add
    import product_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] product,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     clamp
);
    logic signed [ACC_W:0] wide;

    assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){product[PROD_W-1]}}, product};

    // One guard bit is enough: the two top bits disagree exactly when the
    // true sum falls outside the ACC_W-bit range.
    always_comb begin
        clamp = (wide[ACC_W] != wide[ACC_W-1]);
        sum   = wide[ACC_W-1:0];
        if (clamp)
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
endmodule

// File: rtl/product_accumulator.sv
// Sums fixed-length blocks of Booth products with saturation and presents
// each block result on a valid/ready handshake.
module product_accumulator
    import product_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = 4
) (
    input logic                    clk,
    input logic                    reset,
    product_accumulator_if.slave   bus
);
    state_e                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum;
    logic                    clamp;
    logic [LEN_W:0]          count;
    logic [LEN_W:0]          count_nxt;
    logic [LEN_W:0]          target;
    logic [LEN_W-1:0]        len_q;
    logic                    ovf;
    logic                    ovf_nxt;
    logic                    block_done;
    logic                    accept;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    overflow_q;
    logic signed [ACC_W-1:0] acc_out_q;

    // A block's first product starts from zero, so the adder serves both cases.
    assign acc_base  = (state == ST_ACCUM) ? acc : '0;
    assign count_nxt = count + (LEN_W+1)'(1);
    assign target    = {(len_q == '0), len_q};
    assign accept    = bus.in_valid && in_ready_q;
    assign ovf_nxt   = ((state == ST_ACCUM) ? ovf : 1'b0) | clamp;
    assign block_done = (state == ST_IDLE) ? (bus.len == LEN_W'(1)) : (count_nxt == target);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .acc     (acc_base),
        .product (bus.product),
        .sum     (sum),
        .clamp   (clamp)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            acc         <= '0;
            count       <= '0;
            len_q       <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            acc_out_q   <= '0;
        end else if (bus.clear) begin
            state       <= ST_IDLE;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc   <= sum;
                        ovf   <= ovf_nxt;
                        count <= (state == ST_IDLE) ? (LEN_W+1)'(1) : count_nxt;
                        if (state == ST_IDLE) begin
                            len_q      <= bus.len;
                            overflow_q <= 1'b0;
                        end
                        if (block_done) begin
                            state       <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            acc_out_q   <= sum;
                            overflow_q  <= ovf_nxt;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.overflow  = overflow_q;
endmodule
